// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: user-input side of the clock. Conditions the three keys and
// the set switch, runs the time-setting FSM over a shadow copy of the current
// time, and strobes load_o once when set mode is left so the core picks up
// the edited HH:MM:SS.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 12_500_000
) (
  input  logic       clk_50mhz_i,
  input  logic       master_nreset_switch_i,
  input  logic       key1_i,
  input  logic       key2_i,
  input  logic       key3_i,
  input  logic       set_switch_i,
  input  logic [4:0] cur_hr_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic       set_mode_o,
  output logic [1:0] field_sel_o,
  output logic       blink_o,
  output logic [4:0] set_hr_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       load_o
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
  localparam int N_IN = 4;
  // Idle levels: keys are active-low (idle high), the switch idles low.
  localparam logic [3:0] LEVEL_RST = 4'b0111;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  // Bit 0..2 = key1..key3, bit 3 = set switch.
  logic [3:0]       raw_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       level_r;
  logic [DEB_W-1:0] deb_cnt_r [N_IN];
  logic [2:0]       level_prev_r;
  logic [2:0]       press_r;
  logic             switch_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [4:0]       hr_nxt_s;
  logic [5:0]       min_nxt_s;
  logic [5:0]       sec_nxt_s;
  logic             set_mode_nxt_s;

  logic             set_mode_r;
  logic [1:0]       field_sel_r;
  logic             load_r;
  logic [4:0]       set_hr_r;
  logic [5:0]       set_min_r;
  logic [5:0]       set_sec_r;
  logic [BLK_W-1:0] blink_cnt_r;
  logic             blink_r;

  // Increment with wrap to zero above top.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    if (v >= top) begin
      wrap_inc = 6'd0;
    end else begin
      wrap_inc = v + 6'd1;
    end
  endfunction

  // Decrement with wrap from zero to top.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
    if ((v == 6'd0) || (v > top)) begin
      wrap_dec = top;
    end else begin
      wrap_dec = v - 6'd1;
    end
  endfunction

  // True for the three editing states.
  function automatic logic in_set(input state_t s);
    case (s)
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: in_set = 1'b1;
      default:                           in_set = 1'b0;
    endcase
  endfunction

  // Field-select code presented for a state.
  function automatic logic [1:0] field_code(input state_t s);
    case (s)
      ST_SET_HR:  field_code = 2'b01;
      ST_SET_MIN: field_code = 2'b10;
      ST_SET_SEC: field_code = 2'b11;
      default:    field_code = 2'b00;
    endcase
  endfunction

  assign raw_s          = {set_switch_i, key3_i, key2_i, key1_i};
  assign switch_s       = level_r[3];
  assign set_mode_nxt_s = in_set(state_nxt_s);

  // Two-flop synchroniser for every raw board input.
  always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
    if (!master_nreset_switch_i) begin
      sync1_r <= LEVEL_RST;
      sync2_r <= LEVEL_RST;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
    if (!master_nreset_switch_i) begin
      level_r <= LEVEL_RST;
      for (int i = 0; i < N_IN; i++) begin
        deb_cnt_r[i] <= {DEB_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          level_r[i]   <= sync2_r[i];
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + {{(DEB_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // One-cycle press pulse on each debounced key falling edge.
  always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
    if (!master_nreset_switch_i) begin
      level_prev_r <= 3'b111;
      press_r      <= 3'b000;
    end else begin
      level_prev_r <= level_r[2:0];
      press_r      <= level_prev_r & ~level_r[2:0];
    end
  end

  // Next-state and shadow-time edit logic.
  always_comb begin
    state_nxt_s = state_r;
    hr_nxt_s    = set_hr_r;
    min_nxt_s   = set_min_r;
    sec_nxt_s   = set_sec_r;
    case (state_r)
      ST_RUN: begin
        if (switch_s) begin
          state_nxt_s = ST_SET_HR;
          hr_nxt_s    = cur_hr_i;
          min_nxt_s   = cur_min_i;
          sec_nxt_s   = cur_sec_i;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
        if (!switch_s) begin
          state_nxt_s = ST_COMMIT;
        end else if (press_r[0]) begin
          // key1 wins over the edit keys in the same cycle.
          case (state_r)
            ST_SET_HR:  state_nxt_s = ST_SET_MIN;
            ST_SET_MIN: state_nxt_s = ST_SET_SEC;
            default:    state_nxt_s = ST_SET_HR;
          endcase
        end else if (press_r[1] ^ press_r[2]) begin
          // Exactly one of increment/decrement; both together cancel.
          case (state_r)
            ST_SET_HR: begin
              hr_nxt_s = press_r[1] ? 5'(wrap_inc({1'b0, set_hr_r}, 6'd23))
                                    : 5'(wrap_dec({1'b0, set_hr_r}, 6'd23));
            end
            ST_SET_MIN: begin
              min_nxt_s = press_r[1] ? wrap_inc(set_min_r, 6'd59)
                                     : wrap_dec(set_min_r, 6'd59);
            end
            default: begin
              sec_nxt_s = press_r[1] ? wrap_inc(set_sec_r, 6'd59)
                                     : wrap_dec(set_sec_r, 6'd59);
            end
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_COMMIT: state_nxt_s = ST_RUN;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // State, shadow time and registered status outputs.
  always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
    if (!master_nreset_switch_i) begin
      state_r     <= ST_RUN;
      set_hr_r    <= 5'd0;
      set_min_r   <= 6'd0;
      set_sec_r   <= 6'd0;
      set_mode_r  <= 1'b0;
      field_sel_r <= 2'b00;
      load_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      set_hr_r    <= hr_nxt_s;
      set_min_r   <= min_nxt_s;
      set_sec_r   <= sec_nxt_s;
      set_mode_r  <= set_mode_nxt_s;
      field_sel_r <= field_code(state_nxt_s);
      load_r      <= (state_nxt_s == ST_COMMIT);
    end
  end

  // Blink generator: high for the first BLINK_CYCLES after entry, then toggles.
  always_ff @(posedge clk_50mhz_i or negedge master_nreset_switch_i) begin
    if (!master_nreset_switch_i) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_r     <= 1'b0;
    end else if (set_mode_nxt_s && (state_r == ST_RUN)) begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_r     <= 1'b1;
    end else if (set_mode_nxt_s) begin
      if (blink_cnt_r == BLK_LAST) begin
        blink_cnt_r <= {BLK_W{1'b0}};
        blink_r     <= ~blink_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + {{(BLK_W-1){1'b0}}, 1'b1};
      end
    end else begin
      blink_cnt_r <= {BLK_W{1'b0}};
      blink_r     <= 1'b0;
    end
  end

  assign set_mode_o  = set_mode_r;
  assign field_sel_o = field_sel_r;
  assign blink_o     = blink_r;
  assign set_hr_o    = set_hr_r;
  assign set_min_o   = set_min_r;
  assign set_sec_o   = set_sec_r;
  assign load_o      = load_r;

endmodule
